// File: rtl/tawas_dmem_arb_if.sv
// Bus bundle between NREQ tawas load/store masters, the data-memory arbiter and the memory macro.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface tawas_dmem_arb_if #(
   parameter int NREQ = 4,
   parameter int AW   = 32
);
   logic [NREQ-1:0]    REQ_CS;
   logic [NREQ-1:0]    REQ_WR;
   logic [NREQ*AW-1:0] REQ_ADDR;
   logic [NREQ*4-1:0]  REQ_MASK;
   logic [NREQ*32-1:0] REQ_DOUT;
   logic [NREQ-1:0]    REQ_GNT;
   logic [NREQ-1:0]    REQ_RVLD;
   logic [31:0]        REQ_DIN;
   logic               DCS;
   logic               DWR;
   logic [AW-1:0]      DADDR;
   logic [3:0]         DMASK;
   logic [31:0]        DOUT;
   logic [31:0]        DIN;

   modport slave (
      input  REQ_CS, REQ_WR, REQ_ADDR, REQ_MASK, REQ_DOUT, DIN,
      output REQ_GNT, REQ_RVLD, REQ_DIN, DCS, DWR, DADDR, DMASK, DOUT
   );

   modport master (
      output REQ_CS, REQ_WR, REQ_ADDR, REQ_MASK, REQ_DOUT, DIN,
      input  REQ_GNT, REQ_RVLD, REQ_DIN, DCS, DWR, DADDR, DMASK, DOUT
   );
endinterface

// File: rtl/tawas_dmem_arb.sv
// Round-robin arbiter sharing one single-ported data memory between NREQ tawas masters.
// Grant in cycle T, memory strobe in T+1, read-data-valid strobe in T+2; one transfer per cycle.
module tawas_dmem_arb #(
   parameter int NREQ = 4,
   parameter int AW   = 32
) (
   input  logic              CLK,
   input  logic              RST,
   tawas_dmem_arb_if.slave   bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   ptr_q, ptr_d;
   logic            dcs_q, dcs_d;
   logic            dwr_q, dwr_d;
   logic [AW-1:0]   daddr_q, daddr_d;
   logic [3:0]      dmask_q, dmask_d;
   logic [31:0]     dout_q, dout_d;
   logic            rd_vld_q, rd_vld_d;
   logic [PW-1:0]   rd_idx_q, rd_idx_d;
   logic [NREQ-1:0] rvld_q, rvld_d;

   logic [NREQ-1:0] gnt;
   logic            gnt_vld;
   logic [PW-1:0]   gnt_idx;
   logic [PW-1:0]   scan_idx;
   logic            sel_wr;
   logic [AW-1:0]   sel_addr;
   logic [3:0]      sel_mask;
   logic [31:0]     sel_dout;

   // Scan from the priority pointer, wrapping; the first active requester wins.
   always_comb begin
      gnt      = '0;
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      scan_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = PW'((int'(ptr_q) + k) % NREQ);
         if (RST && !gnt_vld && bus.REQ_CS[scan_idx]) begin
            gnt_vld       = 1'b1;
            gnt_idx       = scan_idx;
            gnt[scan_idx] = 1'b1;
         end
      end
   end

   always_comb begin
      sel_wr   = bus.REQ_WR[gnt_idx];
      sel_addr = bus.REQ_ADDR[int'(gnt_idx)*AW +: AW];
      sel_mask = bus.REQ_MASK[int'(gnt_idx)*4 +: 4];
      sel_dout = bus.REQ_DOUT[int'(gnt_idx)*32 +: 32];
   end

   // Idle cycles keep the last address/mask/data so unrequested X never reaches the macro.
   always_comb begin
      ptr_d    = ptr_q;
      dcs_d    = gnt_vld;
      dwr_d    = gnt_vld & sel_wr;
      daddr_d  = daddr_q;
      dmask_d  = dmask_q;
      dout_d   = dout_q;
      rd_vld_d = gnt_vld & ~sel_wr;
      rd_idx_d = rd_idx_q;
      rvld_d   = '0;
      if (gnt_vld) begin
         ptr_d    = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
         daddr_d  = sel_addr;
         dmask_d  = sel_mask;
         dout_d   = sel_dout;
         rd_idx_d = gnt_idx;
      end
      if (rd_vld_q) begin
         rvld_d[rd_idx_q] = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         ptr_q    <= '0;
         dcs_q    <= 1'b0;
         dwr_q    <= 1'b0;
         daddr_q  <= '0;
         dmask_q  <= '0;
         dout_q   <= '0;
         rd_vld_q <= 1'b0;
         rd_idx_q <= '0;
         rvld_q   <= '0;
      end else begin
         ptr_q    <= ptr_d;
         dcs_q    <= dcs_d;
         dwr_q    <= dwr_d;
         daddr_q  <= daddr_d;
         dmask_q  <= dmask_d;
         dout_q   <= dout_d;
         rd_vld_q <= rd_vld_d;
         rd_idx_q <= rd_idx_d;
         rvld_q   <= rvld_d;
      end
   end

   assign bus.REQ_GNT  = gnt;
   assign bus.REQ_RVLD = rvld_q;
   assign bus.REQ_DIN  = bus.DIN;
   assign bus.DCS      = dcs_q;
   assign bus.DWR      = dwr_q;
   assign bus.DADDR    = daddr_q;
   assign bus.DMASK    = dmask_q;
   assign bus.DOUT     = dout_q;
endmodule

// File: tb/tb_tawas_dmem_arb.sv
// Bench for tawas_dmem_arb: directed scenarios then random traffic, checked every cycle against
// a timestamped transaction scoreboard and a reference memory updated in grant order.
module tb_tawas_dmem_arb;
   localparam int NREQ = 4;
   localparam int AW   = 32;

   typedef struct {
      int              cyc;
      int              idx;
      bit              wr;
      logic [AW-1:0]   addr;
      logic [3:0]      mask;
      logic [31:0]     wdata;
      logic [31:0]     rdata;
   } txn_t;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   tawas_dmem_arb_if #(.NREQ(NREQ), .AW(AW)) bus ();

   tawas_dmem_arb #(.NREQ(NREQ), .AW(AW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;
   int cycle = 0;
   int ptr_m = 0;
   int g_m   = -1;

   bit            req_cs   [NREQ];
   bit            req_wr   [NREQ];
   logic [AW-1:0] req_addr [NREQ];
   logic [3:0]    req_mask [NREQ];
   logic [31:0]   req_dout [NREQ];

   txn_t          txq[$];
   logic [AW-1:0] last_addr = '0;
   logic [3:0]    last_mask = '0;
   logic [31:0]   last_dout = '0;

   logic [31:0] mac_mem [logic [AW-1:0]];
   logic [31:0] ref_mem [logic [AW-1:0]];

   function automatic logic [31:0] init_word(logic [AW-1:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   // Memory macro: acts on the strobe at the clock edge, read data valid the following cycle.
   always @(posedge CLK) begin
      logic [31:0] cur;
      if (bus.DCS === 1'b1) begin
         cur = mac_mem.exists(bus.DADDR) ? mac_mem[bus.DADDR] : init_word(bus.DADDR);
         if (bus.DWR === 1'b1) mac_mem[bus.DADDR] = merge(cur, bus.DOUT, bus.DMASK);
         else bus.DIN <= cur;
      end
   end

   function automatic logic [31:0] ref_rd(logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", tag, cycle, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a,
                          input logic [3:0] m, input logic [31:0] d);
      req_cs[i]   = 1'b1;
      req_wr[i]   = wr;
      req_addr[i] = a;
      req_mask[i] = m;
      req_dout[i] = d;
   endtask

   task automatic apply_stimulus();
      for (int i = 0; i < NREQ; i++) begin
         bus.REQ_CS[i] = req_cs[i];
         if (req_cs[i]) begin
            bus.REQ_WR[i]              = req_wr[i];
            bus.REQ_ADDR[i*AW +: AW]   = req_addr[i];
            bus.REQ_MASK[i*4 +: 4]     = req_mask[i];
            bus.REQ_DOUT[i*32 +: 32]   = req_dout[i];
         end else begin
            bus.REQ_WR[i]              = 1'bx;
            bus.REQ_ADDR[i*AW +: AW]   = 'x;
            bus.REQ_MASK[i*4 +: 4]     = 'x;
            bus.REQ_DOUT[i*32 +: 32]   = 'x;
         end
      end
   endtask

   task automatic check_output();
      logic [NREQ-1:0] exp_gnt;
      logic [NREQ-1:0] exp_rvld;
      int iss;
      int ret;
      g_m = -1;
      if (RST) begin
         for (int k = 0; k < NREQ; k++) begin
            if (g_m < 0 && req_cs[(ptr_m + k) % NREQ]) g_m = (ptr_m + k) % NREQ;
         end
      end
      exp_gnt = '0;
      if (g_m >= 0) exp_gnt[g_m] = 1'b1;
      check("gnt", bus.REQ_GNT, exp_gnt);

      iss = -1;
      ret = -1;
      foreach (txq[n]) begin
         if (txq[n].cyc == cycle - 1) iss = n;
         if (txq[n].cyc == cycle - 2 && !txq[n].wr) ret = n;
      end
      if (iss >= 0) begin
         last_addr = txq[iss].addr;
         last_mask = txq[iss].mask;
         last_dout = txq[iss].wdata;
         check("dcs", bus.DCS, 1'b1);
         check("dwr", bus.DWR, txq[iss].wr);
      end else begin
         check("dcs", bus.DCS, 1'b0);
         check("dwr", bus.DWR, 1'b0);
      end
      check("daddr", bus.DADDR, last_addr);
      check("dmask", bus.DMASK, last_mask);
      check("dout", bus.DOUT, last_dout);

      exp_rvld = '0;
      if (ret >= 0) exp_rvld[txq[ret].idx] = 1'b1;
      check("rvld", bus.REQ_RVLD, exp_rvld);
      if (ret >= 0) check("rdin", bus.REQ_DIN, txq[ret].rdata);
   endtask

   task automatic run_cycle();
      txn_t t;
      apply_stimulus();
      @(negedge CLK);
      check_output();
      @(posedge CLK);
      if (!RST) begin
         txq.delete();
         ptr_m     = 0;
         last_addr = '0;
         last_mask = '0;
         last_dout = '0;
      end else if (g_m >= 0) begin
         t.cyc   = cycle;
         t.idx   = g_m;
         t.wr    = req_wr[g_m];
         t.addr  = req_addr[g_m];
         t.mask  = req_mask[g_m];
         t.wdata = req_dout[g_m];
         t.rdata = ref_rd(t.addr);
         if (t.wr) ref_mem[t.addr] = merge(t.rdata, t.wdata, t.mask);
         txq.push_back(t);
         ptr_m      = (g_m + 1) % NREQ;
         req_cs[g_m] = 1'b0;
      end
      cycle++;
      while (txq.size() > 0 && txq[0].cyc < cycle - 2) void'(txq.pop_front());
      #1;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      return AW'(32'h200 + ($urandom_range(0, 7) << 2));
   endfunction

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         req_cs[i] = 1'b0;
         req_wr[i] = 1'b0;
      end
      apply_stimulus();
      repeat (2) @(posedge CLK);
      #1;
      // Reset state, with a request present that must not be granted.
      set_req(1, 1'b0, 32'h40, 4'hF, 32'h0);
      run_cycle();
      RST = 1'b1;
      req_cs[1] = 1'b0;
      run_cycle();

      // Single read by requester 2.
      mac_mem[32'h100] = 32'hDEAD_BEEF;
      ref_mem[32'h100] = 32'hDEAD_BEEF;
      set_req(2, 1'b0, 32'h100, 4'hF, 32'h1234_5678);
      repeat (4) run_cycle();

      // All four requesting continuously.
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < NREQ; i++)
            if (!req_cs[i]) set_req(i, 1'b0, rand_addr(), 4'hF, $urandom);
         run_cycle();
      end
      for (int i = 0; i < NREQ; i++) req_cs[i] = 1'b0;
      repeat (3) run_cycle();

      // Wrap: pointer at 3 with requesters 0 and 3 active.
      set_req(2, 1'b0, 32'h104, 4'hF, 32'h0);
      run_cycle();
      for (int c = 0; c < 5; c++) begin
         if (!req_cs[0]) set_req(0, 1'b0, rand_addr(), 4'hF, $urandom);
         if (!req_cs[3]) set_req(3, 1'b0, rand_addr(), 4'hF, $urandom);
         run_cycle();
      end
      for (int i = 0; i < NREQ; i++) req_cs[i] = 1'b0;
      repeat (3) run_cycle();

      // Masked write then read-back.
      set_req(1, 1'b1, 32'h20, 4'b0011, 32'h0000_ABCD);
      repeat (3) run_cycle();
      set_req(1, 1'b0, 32'h20, 4'hF, 32'h0);
      repeat (3) run_cycle();

      // Read, write, read of the same address on consecutive grants.
      set_req(0, 1'b0, 32'h300, 4'hF, 32'h0);
      run_cycle();
      set_req(1, 1'b1, 32'h300, 4'b1001, 32'hCAFE_F00D);
      run_cycle();
      set_req(2, 1'b0, 32'h300, 4'hF, 32'h0);
      repeat (4) run_cycle();

      // Reset the cycle after a read grant; then requester 3 alone after release.
      set_req(0, 1'b0, 32'h104, 4'hF, 32'h0);
      run_cycle();
      RST = 1'b0;
      run_cycle();
      RST = 1'b1;
      set_req(3, 1'b0, 32'h108, 4'hF, 32'h0);
      repeat (4) run_cycle();

      // Random traffic with occasional reset.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++)
            if (!req_cs[i] && $urandom_range(0, 1) == 1)
               set_req(i, 1'($urandom_range(0, 1)), rand_addr(), 4'($urandom), $urandom);
         RST = ($urandom_range(0, 63) != 0);
         run_cycle();
      end
      RST = 1'b1;
      for (int i = 0; i < NREQ; i++) req_cs[i] = 1'b0;
      repeat (3) run_cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
